// File: rtl/ram_pkg.sv
// ram_pkg: shared constants and FSM encoding for the RAM built-in self test.
// Holds the RAM geometry (ADDR_W, DATA_W, DEPTH), the width and ceiling of
// the mismatch counter, and the controller state encoding.
package ram_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam int ERR_W = 4;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_W0     = 3'd1,
    ST_R0_RD  = 3'd2,
    ST_R0_CMP = 3'd3,
    ST_R0_WR  = 3'd4,
    ST_R1_RD  = 3'd5,
    ST_R1_CMP = 3'd6,
    ST_DONE   = 3'd7
  } bist_state_e;

endpackage

// File: rtl/ram_bist.sv
// ram_bist: march-style self test for a synchronous single-port RAM.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for start; results of the last run are held
// W0        | write pattern+addr to every address, ascending
// R0_RD     | issue read of addr
// R0_CMP    | compare read data with pattern+addr
// R0_WR     | write ~(pattern+addr) back to addr
// R1_RD     | issue read of addr
// R1_CMP    | compare read data with ~(pattern+addr)
// DONE      | one-cycle done pulse, pass is valid
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start, pattern      run request pulse and seed word captured with it
//   ram_en, ram_we      RAM enable / write enable
//   ram_addres          RAM address
//   ram_data_in         RAM write data
//   ram_data_out        RAM read data (valid the cycle after a read)
//   busy, done          run in progress / end-of-run pulse
//   pass, fail_addr     result flag and address of the first mismatch
//   err_count           mismatch count, saturating
module ram_bist #(
  parameter int ADDR_W = ram_pkg::ADDR_W,
  parameter int DATA_W = ram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] pattern,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addres,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [3:0]        err_count
);

  import ram_pkg::*;

  bist_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] pattern_q, pattern_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic              pass_q, pass_d;

  logic              en_raw, we_raw;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] exp_word;
  logic              last_addr;
  logic              mismatch;

  assign exp_word  = pattern_q + DATA_W'(addr_q);
  assign last_addr = &addr_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pattern_d   = pattern_q;
    err_d       = err_q;
    fail_addr_d = fail_addr_q;
    pass_d      = pass_q;
    en_raw      = 1'b0;
    we_raw      = 1'b0;
    wdata       = '0;
    mismatch    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_W0;
          addr_d      = '0;
          pattern_d   = pattern;
          err_d       = '0;
          fail_addr_d = '0;
        end
      end
      ST_W0: begin
        en_raw = 1'b1;
        we_raw = 1'b1;
        wdata  = exp_word;
        if (last_addr) begin
          state_d = ST_R0_RD;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      ST_R0_RD: begin
        en_raw  = 1'b1;
        state_d = ST_R0_CMP;
      end
      ST_R0_CMP: begin
        mismatch = (ram_data_out != exp_word);
        state_d  = ST_R0_WR;
      end
      ST_R0_WR: begin
        en_raw = 1'b1;
        we_raw = 1'b1;
        wdata  = ~exp_word;
        if (last_addr) begin
          state_d = ST_R1_RD;
          addr_d  = '0;
        end else begin
          state_d = ST_R0_RD;
          addr_d  = addr_q + 1'b1;
        end
      end
      ST_R1_RD: begin
        en_raw  = 1'b1;
        state_d = ST_R1_CMP;
      end
      ST_R1_CMP: begin
        mismatch = (ram_data_out != ~exp_word);
        if (last_addr) begin
          state_d = ST_DONE;
          addr_d  = '0;
        end else begin
          state_d = ST_R1_RD;
          addr_d  = addr_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An empty counter means no earlier mismatch in this run, so it doubles
    // as the first-failure flag for fail_addr.
    if (mismatch) begin
      if (err_q == '0) begin
        fail_addr_d = addr_q;
      end
      if (err_q != ERR_MAX) begin
        err_d = err_q + 1'b1;
      end
    end

    // Resolve pass on entry to DONE so it already includes the final compare.
    if (state_q == ST_R1_CMP && last_addr) begin
      pass_d = (err_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      pattern_q   <= '0;
      err_q       <= '0;
      fail_addr_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pattern_q   <= pattern_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      pass_q      <= pass_d;
    end
  end

  // Gating with rst keeps the RAM from being written on the aborting edge.
  assign ram_en      = en_raw & ~rst;
  assign ram_we      = we_raw & ~rst;
  assign ram_addres  = addr_q;
  assign ram_data_in = wdata;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign pass        = pass_q;
  assign fail_addr   = fail_addr_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_ram_bist.sv
module tb_ram_bist;
  import ram_pkg::*;

  localparam int AW = ADDR_W;
  localparam int DW = DATA_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] pattern;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addres;
  logic [DW-1:0] ram_data_in, ram_data_out;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [3:0]    err_count;

  int errors = 0;
  int checks = 0;
  logic mon_on = 1'b0;

  always #5 clk = ~clk;

  ram_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addres(ram_addres),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .err_count(err_count)
  );

  // Behavioural synchronous RAM with a read-path fault injector.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q;
  logic [AW-1:0] rd_addr_q;
  int fault_mode = 0;
  int flt_addr = 0;
  int flt_bit = 0;

  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addres] <= ram_data_in;
    else if (ram_en) begin
      rd_q      <= mem[ram_addres];
      rd_addr_q <= ram_addres;
    end
  end

  function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input int a,
                                           input int mode, input int fa, input int fb);
    case (mode)
      1: return (a == 3) ? (v | DW'(1)) : v;
      2: return '0;
      3: return (a == fa) ? (v ^ (DW'(1) << fb)) : v;
      default: return v;
    endcase
  endfunction

  assign ram_data_out = faulty(rd_q, int'(rd_addr_q), fault_mode, flt_addr, flt_bit);

  always @(negedge clk) begin
    if (mon_on) begin
      checks++;
      if (ram_we && !ram_en) begin
        errors++;
        $display("FAIL monitor_we_without_en: we=%b en=%b want en=1", ram_we, ram_en);
      end
      checks++;
      if (int'(ram_addres) >= DEPTH) begin
        errors++;
        $display("FAIL monitor_addr_range: got %0d want <%0d", ram_addres, DEPTH);
      end
    end
  end

  // Reference: march result from plain loops over the address space.
  task automatic model(input logic [DW-1:0] p, input int mode, input int fa, input int fb,
                       output int exp_err, output int exp_fail, output logic exp_pass);
    int cnt = 0;
    int first = -1;
    logic [DW-1:0] e;
    for (int a = 0; a < DEPTH; a++) begin
      e = p + DW'(a);
      if (faulty(e, a, mode, fa, fb) != e) begin
        if (first < 0) first = a;
        cnt++;
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      e = ~(p + DW'(a));
      if (faulty(e, a, mode, fa, fb) != e) begin
        if (first < 0) first = a;
        cnt++;
      end
    end
    exp_err  = (cnt > 15) ? 15 : cnt;
    exp_fail = (first < 0) ? 0 : first;
    exp_pass = (cnt == 0);
  endtask

  task automatic run_case(input string name, input logic [DW-1:0] p, input int mode,
                          input int fa, input int fb, input int restart_at);
    int exp_err, exp_fail;
    logic exp_pass;
    logic [3:0] e_ctl, g_ctl;
    int e_addr, j, a;
    logic [DW-1:0] e_din;
    logic e_en, e_we;
    fault_mode = mode;
    flt_addr   = fa;
    flt_bit    = fb;
    model(p, mode, fa, fb, exp_err, exp_fail, exp_pass);
    pattern = p;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    pattern = DW'($urandom);
    for (int k = 1; k <= 55; k++) begin
      e_en = 1'b0; e_we = 1'b0; e_addr = 0; e_din = '0;
      if (k <= 8) begin
        e_en = 1'b1; e_we = 1'b1; e_addr = k - 1; e_din = p + DW'(k - 1);
      end else if (k <= 32) begin
        j = k - 9; a = j / 3; e_addr = a;
        if (j % 3 == 0) e_en = 1'b1;
        if (j % 3 == 2) begin e_en = 1'b1; e_we = 1'b1; e_din = ~(p + DW'(a)); end
      end else if (k <= 48) begin
        j = k - 33; a = j / 2; e_addr = a;
        if (j % 2 == 0) e_en = 1'b1;
      end
      e_ctl = {e_en, e_we, (k <= 49), (k == 49)};
      g_ctl = {ram_en, ram_we, busy, done};
      checks++;
      if (g_ctl !== e_ctl) begin
        errors++;
        $display("FAIL %s ctl cycle %0d: got en/we/busy/done=%b want %b", name, k, g_ctl, e_ctl);
      end
      checks++;
      if (int'(ram_addres) != e_addr) begin
        errors++;
        $display("FAIL %s addr cycle %0d: got %0d want %0d", name, k, ram_addres, e_addr);
      end
      if (e_we) begin
        checks++;
        if (ram_data_in !== e_din) begin
          errors++;
          $display("FAIL %s data_in cycle %0d: got %h want %h", name, k, ram_data_in, e_din);
        end
      end
      if (k == 1) begin
        checks++;
        if (err_count !== 4'd0 || fail_addr !== '0) begin
          errors++;
          $display("FAIL %s clear_on_start: got err=%0d fail=%0d want 0/0", name, err_count, fail_addr);
        end
      end
      if (k == 49 || k == 55) begin
        checks++;
        if (pass !== exp_pass || int'(err_count) != exp_err || int'(fail_addr) != exp_fail) begin
          errors++;
          $display("FAIL %s result cycle %0d: got pass=%b err=%0d fail=%0d want pass=%b err=%0d fail=%0d",
                   name, k, pass, err_count, fail_addr, exp_pass, exp_err, exp_fail);
        end
      end
      start = (k == restart_at);
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (mem[i] !== ~(p + DW'(i))) begin
        errors++;
        $display("FAIL %s mem[%0d]: got %h want %h", name, i, mem[i], ~(p + DW'(i)));
      end
    end
    fault_mode = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; pattern = DW'($urandom);
    repeat (3) @(negedge clk);
    mon_on = 1'b1;
    checks++;
    if ({ram_en, ram_we, ram_addres, ram_data_in, busy, done, pass, fail_addr, err_count} !== '0) begin
      errors++;
      $display("FAIL reset_values: got en=%b we=%b addr=%0d din=%h busy=%b done=%b pass=%b fail=%0d err=%0d want all 0",
               ram_en, ram_we, ram_addres, ram_data_in, busy, done, pass, fail_addr, err_count);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_during_rst: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_good();
    run_case("good_2A", 8'h2A, 0, 0, 0, 0);
    checks++;
    if (mem[5] !== 8'hD0) begin
      errors++;
      $display("FAIL good_2A_addr5: got %h want d0", mem[5]);
    end
  endtask

  task automatic test_stuck_bit0();
    run_case("stuck_2B", 8'h2B, 1, 0, 0, 0);
    run_case("stuck_2A", 8'h2A, 1, 0, 0, 0);
  endtask

  task automatic test_all_zero();
    run_case("zero_rd", DW'($urandom_range(1, 255)), 2, 0, 0, 0);
  endtask

  task automatic test_back_to_back_start();
    run_case("restart_ignored", DW'($urandom), 0, 0, 0, 20);
  endtask

  task automatic test_random();
    for (int n = 0; n < 5; n++) begin
      run_case("random", DW'($urandom), int'($urandom_range(0, 3)),
               int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DW - 1)), 0);
    end
  endtask

  task automatic test_reset_midrun();
    logic [DW-1:0] p;
    p = DW'($urandom);
    pattern = p; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    #1;
    checks++;
    if (ram_en !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL midrun_rst_gate: got en=%b we=%b want 0/0", ram_en, ram_we);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || ram_en !== 1'b0 || err_count !== 4'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_rst: got busy=%b en=%b err=%0d done=%b want 0/0/0/0",
               busy, ram_en, err_count, done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem[0] !== p) begin
      errors++;
      $display("FAIL midrun_rst_state: got busy=%b mem0=%h want 0/%h", busy, mem[0], p);
    end
    run_case("after_rst", DW'($urandom), 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pattern = '0;
    test_reset();
    test_good();
    test_stuck_bit0();
    test_all_zero();
    test_back_to_back_start();
    test_random();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_bist.md
RAM_BIST -- requirements
Module: ram_bist

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, RAM address width (depth 2**ADDR_W = 8).
REQ-002 SHALL have parameter DATA_W, default 8, RAM word width.
REQ-003 SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock, shared with the ram.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a test run.
REQ-007 pattern  input  DATA_W  seed word, sampled on the accepted start.
REQ-008 ram_en  output  1  drives ram en.
REQ-009 ram_we  output  1  drives ram we.
REQ-010 ram_addres  output  ADDR_W  drives ram addres.
REQ-011 ram_data_in  output  DATA_W  drives ram data_in.
REQ-012 ram_data_out  input  DATA_W  from ram data_out.
REQ-013 busy  output  1  high while a run is in progress.
REQ-014 done  output  1  one-cycle pulse at the end of a run.
REQ-015 pass  output  1  run result: 1 means zero mismatches.
REQ-016 fail_addr  output  ADDR_W  address of the first mismatch.
REQ-017 err_count  output  4  saturating mismatch count.

Function
REQ-018 The ram SHALL be treated as a synchronous RAM: a write occurs on the edge where en=1 and we=1. For a read issued with en=1 and we=0 at edge t, data_out SHALL be valid for compare at edge t+1.
REQ-019 Expected word for address a SHALL be (pattern_q + a) mod 2**DATA_W (phase W0/R0) and its bitwise inverse (phase R0 write / R1).
REQ-020 FSM states SHALL be IDLE, W0, R0_RD, R0_CMP, R0_WR, R1_RD, R1_CMP, DONE.
REQ-021 IDLE->W0 SHALL occur on start=1. start while busy SHALL be ignored.
REQ-022 W0 SHALL write the expected word to addresses 0..7, one per cycle, then go to R0_RD with addr=0.
REQ-023 R0 SHALL perform read (R0_RD) -> compare to expected (R0_CMP) -> write the inverse (R0_WR) per address, ascending; after address 7 it SHALL go to R1_RD with addr=0.
REQ-024 R1 SHALL perform read (R1_RD) -> compare to the inverse (R1_CMP) per address, ascending; after address 7 it SHALL go to DONE.
REQ-025 DONE SHALL assert done for exactly one cycle, then return to IDLE. Total run length SHALL be 8+24+16+1 = 49 cycles from the cycle after the accepted start.
REQ-026 The address counter SHALL wrap 7->0 only at phase transitions and SHALL never index beyond 7.
REQ-027 ram_en SHALL be 1 only in W0, *_RD and R0_WR; ram_we SHALL be 1 only in W0 and R0_WR; both SHALL be 0 in *_CMP, IDLE and DONE.
REQ-028 On a mismatch, err_count SHALL increment and saturate at 15. fail_addr SHALL latch only on the first mismatch of the run.
REQ-029 pass SHALL equal (err_count==0) and SHALL be updated at DONE; pass, fail_addr and err_count SHALL hold until the next accepted start, which clears err_count and fail_addr.
REQ-030 busy SHALL be 1 in every state except IDLE.

Reset
REQ-031 On rst=1 at a clock edge: state=IDLE, ram_en=0, ram_we=0, ram_addres=0, ram_data_in=0, busy=0, done=0, pass=0, fail_addr=0, err_count=0.
REQ-032 rst asserted mid-run SHALL abort the run the next edge with no further ram writes; start in the same cycle as rst SHALL be ignored.

Structure
REQ-033 Package ram_pkg SHALL hold ADDR_W, DATA_W, DEPTH and the FSM state encoding. The ram is shared with its existing bench.
REQ-034 The block SHALL be a single module with no sub-modules; the ram SHALL be instantiated only in the bench, alongside ram_bist.

Verification
REQ-035 Reset then start with pattern=8'h2A against a good ram -> done at cycle 49, pass=1, err_count=0; addr 5 holds 8'hD0 (inverse of 8'h2F).
REQ-036 A fault model forcing data_out bit0 stuck-at-1 on addr 3 -> pass=0, fail_addr=3, err_count=1 (R0 mismatch only, since the inverse has bit0=1), done at cycle 49.
REQ-037 A fault model forcing all reads to 8'h00 -> err_count saturates at 15, fail_addr=0, pass=0.
REQ-038 start pulsed again at cycle 20 of a run -> ignored, single done at cycle 49.
REQ-039 rst asserted at cycle 10 -> next cycle busy=0, ram_en=0, err_count=0; a fresh start afterwards completes with pass=1.
REQ-040 Monitor: ram_we=1 never occurs with ram_en=0; ram_addres stays within 0..7 throughout.
